// File: rtl/transmissao_cores_face.sv
// Reads the nine cells of one face from the 3x3 colour RAM and sends them as a
// 12-byte ASCII frame ("F", face digit, 9 colour letters, LF) over an 8N1 UART.
module transmissao_cores_face #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [2:0] face,
  input  logic [2:0] cor,
  output logic [1:0] linha_cor_addr,
  output logic [1:0] coluna_cor_addr,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int CW = (CLKS_PER_BIT < 3) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  // The two idle cycles before each byte are PREPARA/PROXIMO followed by CARREGA.
  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    CARREGA = 4'd4,
    START   = 4'd5,
    DADOS   = 4'd6,
    STOP    = 4'd7,
    PROXIMO = 4'd8,
    FIM     = 4'd9
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [1:0]    lin_q, lin_d;
  logic [1:0]    col_q, col_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    face_q, face_d;

  // RAM cell {row, col} for frame byte idx; non-colour bytes park at 0,0.
  function automatic logic [3:0] cell_of(input logic [3:0] idx);
    case (idx)
      4'd2:    cell_of = {2'd0, 2'd0};
      4'd3:    cell_of = {2'd0, 2'd1};
      4'd4:    cell_of = {2'd0, 2'd2};
      4'd5:    cell_of = {2'd1, 2'd0};
      4'd6:    cell_of = {2'd1, 2'd1};
      4'd7:    cell_of = {2'd1, 2'd2};
      4'd8:    cell_of = {2'd2, 2'd0};
      4'd9:    cell_of = {2'd2, 2'd1};
      4'd10:   cell_of = {2'd2, 2'd2};
      default: cell_of = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] char_of(input logic [3:0] idx, input logic [2:0] f,
                                         input logic [2:0] c);
    if (idx == 4'd0)       char_of = 8'h46;
    else if (idx == 4'd1)  char_of = (f <= 3'd5) ? (8'h30 + {5'b0, f}) : 8'h3F;
    else if (idx == 4'd11) char_of = 8'h0A;
    else begin
      case (c)
        3'd0:    char_of = 8'h57;
        3'd1:    char_of = 8'h59;
        3'd2:    char_of = 8'h52;
        3'd3:    char_of = 8'h4F;
        3'd4:    char_of = 8'h42;
        3'd5:    char_of = 8'h47;
        default: char_of = 8'h3F;
      endcase
    end
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      lin_q    <= '0;
      col_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      lin_q    <= lin_d;
      col_q    <= col_d;
    end
  end

  always_ff @(posedge clock) begin
    shift_q <= shift_d;
    face_q  <= face_d;
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    lin_d    = lin_q;
    col_d    = col_q;
    shift_d  = shift_q;
    face_d   = face_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          face_d   = face;
          estado_d = PREPARA;
        end
      end
      PREPARA: begin
        byte_d   = '0;
        lin_d    = '0;
        col_d    = '0;
        estado_d = CARREGA;
      end
      CARREGA: begin
        shift_d  = char_of(byte_q, face_q, cor);
        cnt_d    = '0;
        estado_d = START;
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          bit_d    = '0;
          estado_d = DADOS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DADOS: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            // Present the next byte's address early so the RAM read settles well before CARREGA.
            {lin_d, col_d} = cell_of(byte_q + 4'd1);
            estado_d       = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          estado_d = (byte_q == 4'd11) ? FIM : PROXIMO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PROXIMO: begin
        byte_d   = byte_q + 4'd1;
        estado_d = CARREGA;
      end
      FIM:     estado_d = INICIAL;
      default: estado_d = INICIAL;
    endcase
  end

  assign saida_serial    = (estado_q == START) ? 1'b0 :
                           (estado_q == DADOS) ? shift_q[0] : 1'b1;
  assign ocupado         = (estado_q != INICIAL) && (estado_q != FIM);
  assign pronto          = (estado_q == FIM);
  assign db_estado       = estado_q;
  assign linha_cor_addr  = lin_q;
  assign coluna_cor_addr = col_q;

endmodule

// File: tb/tb_transmissao_cores_face.sv
// Bench for transmissao_cores_face: frame-level waveform model, UART decoder
// against literal strings, and a bit-timing probe at the real baud divisor.
module tb_transmissao_cores_face;

  localparam int CPB = 4;
  localparam int L   = 2 + 10 * CPB;
  localparam int FR  = 12 * L;
  localparam int CPB2 = 5208;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [2:0] face = 3'd0;
  logic [2:0] cor = 3'd0;
  logic [1:0] linha_cor_addr, coluna_cor_addr;
  logic       saida_serial, ocupado, pronto;
  logic [3:0] db_estado;

  logic       reset2 = 1'b0;
  logic       iniciar2 = 1'b0;
  logic [2:0] face2 = 3'd0;
  logic [2:0] cor2 = 3'd0;
  logic [1:0] lin2, col2;
  logic       ser2, ocu2, pro2;
  logic [3:0] est2;

  transmissao_cores_face #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .face(face), .cor(cor),
    .linha_cor_addr(linha_cor_addr), .coluna_cor_addr(coluna_cor_addr),
    .saida_serial(saida_serial), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado));

  transmissao_cores_face #(.CLKS_PER_BIT(CPB2)) dut2 (
    .clock(clock), .reset(reset2), .iniciar(iniciar2), .face(face2), .cor(cor2),
    .linha_cor_addr(lin2), .coluna_cor_addr(col2),
    .saida_serial(ser2), .ocupado(ocu2), .pronto(pro2), .db_estado(est2));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Colour RAM with one cycle of read latency.
  logic [2:0] ram [0:3][0:3];
  always @(posedge clock) cor <= ram[linha_cor_addr][coluna_cor_addr];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_period();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] exp_frame [0:11];
  logic [2:0] face_acc;
  int         t0 = 0;
  bit         mon_en = 1'b0;
  int         pr_n = -1;

  task automatic build_frame(input logic [2:0] f);
    string cmap;
    cmap = "WYROBG??";
    exp_frame[0] = 8'h46;
    exp_frame[1] = (f <= 3'd5) ? (8'h30 + 8'(f)) : 8'h3F;
    for (int i = 0; i < 9; i++) exp_frame[2 + i] = cmap[ram[i / 3][i % 3]];
    exp_frame[11] = 8'h0A;
  endtask

  // Expected line level n cycles after the accept cycle.
  function automatic logic exp_line(input int n);
    int m, b, r, s;
    if (n < 1) return 1'b1;
    m = n - 1;
    if (m >= FR) return 1'b1;
    b = m / L;
    r = m % L;
    if (r < 2) return 1'b1;
    s = (r - 2) / CPB;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return exp_frame[b][s - 1];
  endfunction

  function automatic logic [3:0] exp_cell(input int b);
    if (b >= 2 && b <= 10) return {2'((b - 2) / 3), 2'((b - 2) % 3)};
    return 4'd0;
  endfunction

  initial forever begin
    int n, k;
    @(negedge clock);
    if (mon_en) begin
      n = cyc - t0;
      check("serial", {31'd0, saida_serial}, {31'd0, exp_line(n)});
      check("ocupado", {31'd0, ocupado}, {31'd0, (n >= 1 && n <= FR)});
      check("pronto", {31'd0, pronto}, {31'd0, (n == FR + 1)});
      if (pronto === 1'b1) pr_n = n;
      k = n + 1;
      if ((k % L) <= 3 && (k / L) <= 12)
        check("addr", {28'd0, linha_cor_addr, coluna_cor_addr}, {28'd0, exp_cell(k / L)});
      if (n == FR + 2) check("estado_idle", {28'd0, db_estado}, 32'd0);
    end
  end

  logic [7:0] rxq [$];
  initial forever begin
    bit busy;
    int rc, j;
    logic [7:0] rb;
    @(negedge clock);
    if (!reset) busy = 1'b0;
    else if (!busy) begin
      if (saida_serial === 1'b0) begin busy = 1'b1; rc = 0; end
    end else begin
      rc++;
      if (rc % CPB == CPB / 2) begin
        j = rc / CPB - 1;
        if (j >= 0 && j <= 7) rb[j] = saida_serial;
        else if (j == 8) begin
          check("stop_bit", {31'd0, saida_serial}, 32'd1);
          rxq.push_back(rb);
          busy = 1'b0;
        end
      end
    end
  end

  task automatic start_frame();
    face_acc = face;
    build_frame(face_acc);
    rxq.delete();
    pr_n = -1;
    iniciar = 1'b1;
    t0 = cyc;
    mon_en = 1'b1;
    wait_period();
    iniciar = 1'b0;
  endtask

  task automatic run_frame(input int pulse_at, input logic [2:0] face_later, input string lit);
    start_frame();
    for (int k = 1; k <= FR + 3; k++) begin
      if (k == 2) face = face_later;
      iniciar = (k == pulse_at);
      wait_period();
    end
    iniciar = 1'b0;
    mon_en = 1'b0;
    check("pronto_cycle", pr_n, 505);
    check("rx_count", rxq.size(), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("rx_byte%0d", i), (i < rxq.size()) ? {24'd0, rxq[i]} : 32'hFFFF,
            {24'd0, lit[i]});
  endtask

  task automatic load_ram(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    int v [9];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < 16; i++) ram[i / 4][i % 4] = 3'd0;
    for (int i = 0; i < 9; i++) ram[i / 3][i % 3] = 3'(v[i]);
  endtask

  bit done2 = 1'b0;
  initial begin
    int n;
    int nn [7];
    logic ee [7];
    nn = '{2, 3, 10418, 10419, 15627, 20834, 20835};
    ee = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    #23 reset2 = 1'b1;
    wait_period();
    iniciar2 = 1'b1;
    wait_period();
    iniciar2 = 1'b0;
    // accept cycle was the previous period
    while (cyc - (cyc - 1) == 1 && n <= 20836) begin
      @(negedge clock);
      n = n + 1;
      for (int i = 0; i < 7; i++)
        if (n == nn[i]) check($sformatf("baud5208_n%0d", nn[i]), {31'd0, ser2}, {31'd0, ee[i]});
      if (n == 3) check("baud5208_ocupado", {31'd0, ocu2}, 32'd1);
    end
    done2 = 1'b1;
  end

  initial begin
    #3;
    check("rst_serial", {31'd0, saida_serial}, 32'd1);
    check("rst_ocupado", {31'd0, ocupado}, 32'd0);
    check("rst_pronto", {31'd0, pronto}, 32'd0);
    check("rst_addr", {28'd0, linha_cor_addr, coluna_cor_addr}, 32'd0);
    check("rst_estado", {28'd0, db_estado}, 32'd0);
    #20 reset = 1'b1;
    wait_period();
    wait_period();

    load_ram(0, 1, 2, 3, 4, 5, 0, 1, 2);
    face = 3'd3;
    run_frame(-1, 3'd3, "F3WYROBGWYR\n");

    load_ram(6, 7, 5, 4, 3, 2, 1, 0, 6);
    face = 3'd7;
    run_frame(-1, 3'd7, "F???GBORYW?\n");

    load_ram(0, 1, 2, 3, 4, 5, 0, 1, 2);
    face = 3'd3;
    run_frame(100, 3'd1, "F3WYROBGWYR\n");
    face = 3'd3;
    run_frame(-1, 3'd3, "F3WYROBGWYR\n");

    // Abort inside data bit 4 of byte 5 ('O'), where the line is low.
    start_frame();
    while (cyc - t0 < 234) wait_period();
    #5;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_serial", {31'd0, saida_serial}, 32'd1);
    check("abort_ocupado", {31'd0, ocupado}, 32'd0);
    check("abort_pronto", {31'd0, pronto}, 32'd0);
    check("abort_estado", {28'd0, db_estado}, 32'd0);
    check("abort_addr", {28'd0, linha_cor_addr, coluna_cor_addr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_period();
      check("abort_hold_pronto", {31'd0, pronto}, 32'd0);
    end
    reset = 1'b1;
    wait_period();
    run_frame(-1, 3'd3, "F3WYROBGWYR\n");

    for (int i = 0; i < 30000 && !done2; i++) wait_period();
    check("baud5208_done", {31'd0, done2}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
